alu_issue_ctrl: RTL and testbench

Parametrised successor to the execute-stage ALU decoder. It decodes `alu_op`/`fun3`/`fun7` into an `alu_t` operation and fully distinguishes the encodings that need extra fields: SRLI/SRAI, FCVT signed/unsigned, and the four fused-multiply-add variants. It registers the decoded operation into EX and sequences multi-cycle operations (MUL, DIV/REM, FP ops) with a per-class latency counter and a valid/ready handshake toward ID. It sits between ID/EX pipeline control and the ALU/FPU datapath and replaces ad-hoc stalling for long-latency ops.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_decode.sv | 124 ++++++++++++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage issue control: operation encoding,
// alu_op class constants and latency classes.
package alu_pkg;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        FADD, FSUB, FMUL, FDIV, FSQRT, FMIN, FMAX,
        FSGNJ, FSGNJN, FSGNJX, FEQ, FLT, FLE, FCLASS,
        FMV_X_W, FMV_W_X, FCVT_W_S, FCVT_WU_S, FCVT_S_W, FCVT_S_WU,
        FMADD, FMSUB, FNMSUB, FNMADD, FLW, FSW
    } alu_t;

    localparam logic [2:0] LOAD_STORE = 3'b000;
    localparam logic [2:0] I_TYPE     = 3'b001;
    localparam logic [2:0] B_TYPE     = 3'b010;
    localparam logic [2:0] R_TYPE     = 3'b011;
    localparam logic [2:0] R_FLOAT    = 3'b100;
    localparam logic [2:0] R4_FLOAT   = 3'b101;
    localparam logic [2:0] I_FLOAT    = 3'b110;
    localparam logic [2:0] S_FLOAT    = 3'b111;

    // Prefixed so they do not collide with the MUL/DIV operation names.
    typedef enum logic [2:0] {
        LAT_SINGLE, LAT_MUL, LAT_DIV, LAT_FP, LAT_FMA, LAT_FDIV
    } lat_class_t;

    // Base integer op shared by I-type and base R-type; sra picks SRA on fun3=101.
    function automatic alu_t base_op(input logic [2:0] fun3, input logic sra);
        case (fun3)
            3'b000:  return ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return sra ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of alu_op/fun3/fun7 into an operation and latency class.
// FP classes are decoded only when RV32F_EN is defined; otherwise they are illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] fun3,
    input  logic [6:0] fun7,
    input  logic       rs2_lsb,
    input  logic [1:0] fma_sel,
    output alu_t       op,
    output lat_class_t cls,
    output logic       illegal
);

`ifndef RV32F_EN
    logic unused_fp_inputs;
    assign unused_fp_inputs = ^{rs2_lsb, fma_sel};
`endif

    always_comb begin
        op      = ADD;
        cls     = LAT_SINGLE;
        illegal = 1'b0;
        case (alu_op)
            LOAD_STORE: op = ADD;
            I_TYPE:     op = base_op(fun3, fun7[5]);
            B_TYPE: begin
                case (fun3)
                    3'b000, 3'b001: op = SUB;
                    3'b100, 3'b101: op = SLT;
                    3'b110, 3'b111: op = SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            R_TYPE: begin
                case (fun7)
                    7'b0000000: op = base_op(fun3, 1'b0);
                    7'b0100000: begin
                        if (fun3 == 3'b000)      op = SUB;
                        else if (fun3 == 3'b101) op = SRA;
                        else                     illegal = 1'b1;
                    end
                    7'b0000001: begin
                        cls = fun3[2] ? LAT_DIV : LAT_MUL;
                        case (fun3)
                            3'b000:  op = MUL;
                            3'b001:  op = MULH;
                            3'b010:  op = MULHSU;
                            3'b011:  op = MULHU;
                            3'b100:  op = DIV;
                            3'b101:  op = DIVU;
                            3'b110:  op = REM;
                            default: op = REMU;
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
`ifdef RV32F_EN
            R_FLOAT: begin
                cls = LAT_FP;
                case (fun7)
                    7'b0000000: op = FADD;
                    7'b0000100: op = FSUB;
                    7'b0001000: op = FMUL;
                    7'b0001100: begin op = FDIV;  cls = LAT_FDIV; end
                    7'b0101100: begin op = FSQRT; cls = LAT_FDIV; end
                    7'b0010000: begin
                        cls = LAT_SINGLE;
                        case (fun3)
                            3'b000:  op = FSGNJ;
                            3'b001:  op = FSGNJN;
                            3'b010:  op = FSGNJX;
                            default: illegal = 1'b1;
                        endcase
                    end
                    7'b0010100: begin
                        if (fun3 == 3'b000)      op = FMIN;
                        else if (fun3 == 3'b001) op = FMAX;
                        else                     illegal = 1'b1;
                    end
                    7'b1010000: begin
                        cls = LAT_SINGLE;
                        case (fun3)
                            3'b010:  op = FEQ;
                            3'b001:  op = FLT;
                            3'b000:  op = FLE;
                            default: illegal = 1'b1;
                        endcase
                    end
                    7'b1100000: op = rs2_lsb ? FCVT_WU_S : FCVT_W_S;
                    7'b1101000: op = rs2_lsb ? FCVT_S_WU : FCVT_S_W;
                    7'b1110000: begin
                        cls = LAT_SINGLE;
                        if (fun3 == 3'b000)      op = FMV_X_W;
                        else if (fun3 == 3'b001) op = FCLASS;
                        else                     illegal = 1'b1;
                    end
                    7'b1111000: begin op = FMV_W_X; cls = LAT_SINGLE; end
                    default:    illegal = 1'b1;
                endcase
            end
            R4_FLOAT: begin
                cls = LAT_FMA;
                case (fma_sel)
                    2'b00:   op = FMADD;
                    2'b01:   op = FMSUB;
                    2'b10:   op = FNMSUB;
                    default: op = FNMADD;
                endcase
            end
            I_FLOAT: if (fun3 == 3'b010) op = FLW; else illegal = 1'b1;
            S_FLOAT: if (fun3 == 3'b010) op = FSW; else illegal = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            op  = ADD;
            cls = LAT_SINGLE;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue control: registers the decoded op and sequences
// multi-cycle ops with a latency counter. FP decode enabled by RV32F_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33,
    parameter int FP_LAT   = 3,
    parameter int FMA_LAT  = 4,
    parameter int FDIV_LAT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [2:0] alu_op,
    input  logic [2:0] fun3,
    input  logic [6:0] fun7,
    input  logic       rs2_lsb,
    input  logic [1:0] fma_sel,
    input  logic       kill,
    output alu_t       alu_ctrl,
    output logic       ex_start,
    output logic       ex_valid,
    output logic       illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] lat;
    alu_t       dec_op;
    lat_class_t dec_cls;
    logic       dec_illegal;
    logic       accept;

    alu_decode u_dec (
        .alu_op  (alu_op),
        .fun3    (fun3),
        .fun7    (fun7),
        .rs2_lsb (rs2_lsb),
        .fma_sel (fma_sel),
        .op      (dec_op),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_comb begin
        lat = 6'd1;
        case (dec_cls)
            LAT_MUL:  lat = 6'(MUL_LAT);
            LAT_DIV:  lat = 6'(DIV_LAT);
            LAT_FP:   lat = 6'(FP_LAT);
            LAT_FMA:  lat = 6'(FMA_LAT);
            LAT_FDIV: lat = 6'(FDIV_LAT);
            default:  lat = 6'd1;
        endcase
    end

    assign accept = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_ctrl <= ADD;
            id_ready <= 1'b1;
            ex_start <= 1'b0;
            ex_valid <= 1'b0;
            illegal  <= 1'b0;
        end else if (kill) begin
            // Flush drops both the in-flight op and any same-cycle accept.
            state    <= IDLE;
            cnt      <= '0;
            id_ready <= 1'b1;
            ex_start <= 1'b0;
            ex_valid <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            ex_start <= 1'b0;
            ex_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                BUSY: begin
                    if (cnt == 6'd0) begin
                        state    <= DONE;
                        ex_valid <= 1'b1;
                        id_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        alu_ctrl <= dec_op;
                        if (dec_illegal) begin
                            state    <= IDLE;
                            illegal  <= 1'b1;
                            id_ready <= 1'b1;
                        end else begin
                            ex_start <= 1'b1;
                            if (lat <= 6'd1) begin
                                state    <= DONE;
                                ex_valid <= 1'b1;
                                id_ready <= 1'b1;
                            end else begin
                                state    <= BUSY;
                                cnt      <= lat - 6'd2;
                                id_ready <= 1'b0;
                            end
                        end
                    end else begin
                        state    <= IDLE;
                        id_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench: a cycle-indexed event model predicts when
// ex_start/ex_valid/illegal fire and when id_ready drops, from op latencies.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int MUL_LAT = 2, DIV_LAT = 33, FP_LAT = 3, FMA_LAT = 4, FDIV_LAT = 16;

    logic       clk = 1'b0, reset = 1'b1, id_valid = 1'b0, kill = 1'b0, rs2_lsb = 1'b0;
    logic [2:0] alu_op = '0, fun3 = '0;
    logic [6:0] fun7 = '0;
    logic [1:0] fma_sel = '0;
    logic       id_ready, ex_start, ex_valid, illegal;
    alu_t       alu_ctrl;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FP_LAT(FP_LAT),
        .FMA_LAT(FMA_LAT), .FDIV_LAT(FDIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .alu_op(alu_op), .fun3(fun3), .fun7(fun7), .rs2_lsb(rs2_lsb),
        .fma_sel(fma_sel), .kill(kill), .alu_ctrl(alu_ctrl),
        .ex_start(ex_start), .ex_valid(ex_valid), .illegal(illegal)
    );

    int   n_chk = 0, n_err = 0, cyc = 0;
    int   start_at = -1, valid_at = -1, ill_at = -1, ready_from = 0;
    alu_t exp_ctrl = ADD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [2:0] aop, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic r2, input logic [1:0] fs,
                                    output alu_t op, output int lat, output bit ill);
        alu_t base[8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        alu_t mext[8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
        op = ADD; lat = 1; ill = 0;
        case (aop)
            3'd0: op = ADD;
            3'd1: op = (f3 == 3'd5 && f7[5]) ? SRA : base[f3];
            3'd2: if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
                  else op = (f3 < 3'd4) ? SUB : (f3 < 3'd6) ? SLT : SLTU;
            3'd3: begin
                if (f7 == 7'h00) op = base[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) op = SRA;
                else if (f7 == 7'h01) begin op = mext[f3]; lat = f3[2] ? DIV_LAT : MUL_LAT; end
                else ill = 1;
            end
`ifdef RV32F_EN
            3'd4: begin
                alu_t sg[3] = '{FSGNJ, FSGNJN, FSGNJX};
                lat = FP_LAT;
                case (f7)
                    7'h00: op = FADD;
                    7'h04: op = FSUB;
                    7'h08: op = FMUL;
                    7'h0C: begin op = FDIV;  lat = FDIV_LAT; end
                    7'h2C: begin op = FSQRT; lat = FDIV_LAT; end
                    7'h10: begin lat = 1; if (f3 <= 3'd2) op = sg[f3[1:0]]; else ill = 1; end
                    7'h14: if (f3 == 3'd0) op = FMIN; else if (f3 == 3'd1) op = FMAX; else ill = 1;
                    7'h50: begin lat = 1;
                        if (f3 == 3'd0) op = FLE; else if (f3 == 3'd1) op = FLT;
                        else if (f3 == 3'd2) op = FEQ; else ill = 1; end
                    7'h60: op = r2 ? FCVT_WU_S : FCVT_W_S;
                    7'h68: op = r2 ? FCVT_S_WU : FCVT_S_W;
                    7'h70: begin lat = 1;
                        if (f3 == 3'd0) op = FMV_X_W; else if (f3 == 3'd1) op = FCLASS; else ill = 1; end
                    7'h78: begin lat = 1; op = FMV_W_X; end
                    default: ill = 1;
                endcase
            end
            3'd5: begin
                alu_t fm[4] = '{FMADD, FMSUB, FNMSUB, FNMADD};
                op = fm[fs]; lat = FMA_LAT;
            end
            3'd6: if (f3 == 3'd2) op = FLW; else ill = 1;
            3'd7: if (f3 == 3'd2) op = FSW; else ill = 1;
`endif
            default: ill = 1;
        endcase
        if (ill) begin op = ADD; lat = 1; end
    endfunction

    task automatic step(input logic v, input logic [2:0] aop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic r2, input logic [1:0] fs,
                        input logic k, input logic rst);
        alu_t op; int lat; bit ill; bit acc;
        id_valid = v; alu_op = aop; fun3 = f3; fun7 = f7; rs2_lsb = r2;
        fma_sel = fs; kill = k; reset = rst;
        acc = v && (cyc >= ready_from);
        ref_dec(aop, f3, f7, r2, fs, op, lat, ill);
        @(posedge clk);
        if (rst) begin
            exp_ctrl = ADD; start_at = -1; valid_at = -1; ill_at = -1; ready_from = 0;
        end else if (k) begin
            start_at = -1; valid_at = -1; ill_at = -1; ready_from = 0;
        end else if (acc) begin
            exp_ctrl = op;
            if (ill) ill_at = cyc + 1;
            else begin start_at = cyc + 1; valid_at = cyc + lat; ready_from = cyc + lat; end
        end
        #1;
        cyc++;
        chk("id_ready", id_ready, cyc >= ready_from);
        chk("ex_start", ex_start, cyc == start_at);
        chk("ex_valid", ex_valid, cyc == valid_at);
        chk("illegal",  illegal,  cyc == ill_at);
        chk("alu_ctrl", alu_ctrl, exp_ctrl);
    endtask

    task automatic go(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                      input logic r2 = 1'b0, input logic [1:0] fs = 2'b00);
        step(1'b1, aop, f3, f7, r2, fs, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    logic [6:0] f7_pool [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h2C, 7'h10,
                                 7'h14, 7'h50, 7'h60, 7'h68, 7'h70, 7'h78};

    initial begin
        step(1'b0, 3'd0, 3'd0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 3'd0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        // Back-to-back single-cycle R-type.
        go(R_TYPE, 3'd0, 7'h00); go(R_TYPE, 3'd0, 7'h20); go(R_TYPE, 3'd5, 7'h20);
        idle(2);
        // Full DIV, then DIV killed at T+5.
        go(R_TYPE, 3'd4, 7'h01); idle(36);
        go(R_TYPE, 3'd4, 7'h01); idle(4);
        step(1'b0, 3'd0, 3'd0, 7'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(36);
        // Kill coincident with an accept discards it.
        step(1'b1, R_TYPE, 3'd0, 7'h01, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(3);
        go(I_TYPE, 3'd5, 7'h20); go(I_TYPE, 3'd5, 7'h00);
        go(R_FLOAT, 3'd0, 7'h60, 1'b1); idle(4);
        go(R4_FLOAT, 3'd0, 7'h00, 1'b0, 2'b10); idle(6);
        go(R_TYPE, 3'd0, 7'h7F); idle(2);
        go(R_TYPE, 3'd1, 7'h01); go(R_TYPE, 3'd7, 7'h01); idle(3);
        // Reset mid-BUSY.
        go(R_TYPE, 3'd6, 7'h01); idle(5);
        step(1'b0, 3'd0, 3'd0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 2000; i++) begin
            logic [6:0] f7r;
            case ($urandom_range(0, 5))
                0, 1:    f7r = 7'h00;
                2:       f7r = 7'h20;
                3:       f7r = 7'h01;
                4:       f7r = f7_pool[$urandom_range(0, 11)];
                default: f7r = 7'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), f7r,
                 1'($urandom), 2'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 199) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
